cp_job_ctrl: RTL and testbench



---
 rtl/cp_job_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cp_job_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp_job_ctrl.sv
// cp_job_ctrl: host-side job controller for one cp_core/DMEM pair (load operands, run, drain results).
// Optional RUN watchdog with job_err reporting is enabled by defining CP_JOB_TIMEOUT_EN.
module cp_job_ctrl #(
    parameter int CP_D_WIDTH      = 72,
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int TIMEOUT_WIDTH   = 16
) (
    input  logic                       clock,
    input  logic                       nreset,
    // command
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [DMEM_ADDR_WIDTH-1:0] cmd_in_base,
    input  logic [DMEM_ADDR_WIDTH-1:0] cmd_in_len,
    input  logic [DMEM_ADDR_WIDTH-1:0] cmd_out_base,
    input  logic [DMEM_ADDR_WIDTH-1:0] cmd_out_len,
    input  logic [TIMEOUT_WIDTH-1:0]   cmd_timeout,
    // operand stream
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CP_D_WIDTH-1:0]      in_data,
    // result stream
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CP_D_WIDTH-1:0]      out_data,
    output logic                       out_last,
    // core
    output logic                       cp_active,
    input  logic                       cp_nbusy,
    input  logic                       cp_done,
    // DMEM ports
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_w,
    output logic [CP_D_WIDTH-1:0]      dmem_in_w,
    output logic                       dmem_we_w,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_r,
    input  logic [CP_D_WIDTH-1:0]      dmem_out_r,
    // status
    output logic                       job_done,
    output logic                       job_err,
    output logic                       busy,
    output logic [2:0]                 dbg_state
);

    localparam int AW = DMEM_ADDR_WIDTH;
    localparam int DW = CP_D_WIDTH;
    localparam int TW = TIMEOUT_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_RD   = 3'd3,
        S_OUT  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    // Every stream is valid/ready: a word transfers on a rising edge where both are high;
    // a valid that has been raised holds its data until that transfer and never waits on ready.

    state_t          state_q, state_d;
    logic [AW-1:0]   in_base_q, in_base_d;
    logic [AW-1:0]   in_len_q, in_len_d;
    logic [AW-1:0]   out_base_q, out_base_d;
    logic [AW-1:0]   out_len_q, out_len_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            cp_active_q, cp_active_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;

`ifdef CP_JOB_TIMEOUT_EN
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [TW-1:0]   wd_q, wd_d;
    logic            err_q, err_d;
`else
    logic            unused_cmd_timeout;
    assign unused_cmd_timeout = ^cmd_timeout;
`endif

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q     <= S_IDLE;
            in_base_q   <= '0;
            in_len_q    <= '0;
            out_base_q  <= '0;
            out_len_q   <= '0;
            idx_q       <= '0;
            cp_active_q <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef CP_JOB_TIMEOUT_EN
            tmo_q       <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_base_q   <= in_base_d;
            in_len_q    <= in_len_d;
            out_base_q  <= out_base_d;
            out_len_q   <= out_len_d;
            idx_q       <= idx_d;
            cp_active_q <= cp_active_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            raddr_q     <= raddr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifdef CP_JOB_TIMEOUT_EN
            tmo_q       <= tmo_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        in_base_d   = in_base_q;
        in_len_d    = in_len_q;
        out_base_d  = out_base_q;
        out_len_d   = out_len_q;
        idx_d       = idx_q;
        cp_active_d = cp_active_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        raddr_d     = raddr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
`ifdef CP_JOB_TIMEOUT_EN
        tmo_d       = tmo_q;
        wd_d        = '0;
        err_d       = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    in_base_d  = cmd_in_base;
                    in_len_d   = cmd_in_len;
                    out_base_d = cmd_out_base;
                    out_len_d  = cmd_out_len;
                    idx_d      = '0;
`ifdef CP_JOB_TIMEOUT_EN
                    tmo_d      = cmd_timeout;
                    err_d      = 1'b0;
`endif
                    if (cmd_in_len != '0) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d     = S_RUN;
                        cp_active_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (in_valid && in_ready) begin
                    we_d    = 1'b1;
                    waddr_d = in_base_q + idx_q;
                    wdata_d = in_data;
                    idx_d   = idx_q + AW'(1);
                    if (idx_q == in_len_q - AW'(1)) begin
                        state_d     = S_RUN;
                        cp_active_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                // A done sampled in the same cycle as watchdog expiry takes priority.
                if (cp_done && cp_active_q) begin
                    cp_active_d = 1'b0;
                    idx_d       = '0;
                    if (out_len_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RD;
                        raddr_d = out_base_q;
                    end
                end
`ifdef CP_JOB_TIMEOUT_EN
                else if ((tmo_q != '0) && (wd_q + TW'(1) == tmo_q)) begin
                    cp_active_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = S_FIN;
                end else begin
                    wd_d = wd_q + TW'(1);
                end
`endif
            end

            S_RD: begin
                state_d = S_OUT;
            end

            S_OUT: begin
                // First OUT cycle captures the read data; valid is raised from the next cycle.
                if (!out_valid_q) begin
                    out_data_d  = dmem_out_r;
                    out_last_d  = (idx_q == out_len_q - AW'(1));
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    idx_d       = idx_q + AW'(1);
                    if (out_last_q) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RD;
                        raddr_d = out_base_q + idx_q + AW'(1);
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
`ifdef CP_JOB_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready   = nreset && (state_q == S_IDLE);
    assign in_ready    = nreset && (state_q == S_LOAD);
    assign job_done    = nreset && (state_q == S_FIN);
`ifdef CP_JOB_TIMEOUT_EN
    assign job_err     = job_done && err_q;
`else
    assign job_err     = 1'b0;
`endif
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign cp_active   = cp_active_q;
    assign dmem_we_w   = we_q;
    assign dmem_addr_w = waddr_q;
    assign dmem_in_w   = wdata_q;
    assign dmem_addr_r = raddr_q;
    assign busy        = (state_q != S_IDLE) || !cp_nbusy;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_cp_job_ctrl.sv
// Directed bench for cp_job_ctrl: job table driven through a DMEM and core model, plus reset sequences.
`timescale 1ns/1ps
module tb_cp_job_ctrl;

    localparam int DW = 72;
    localparam int AW = 10;
    localparam int TW = 16;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic nreset;
    always #5 clock = ~clock;

    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_in_base, cmd_in_len, cmd_out_base, cmd_out_len;
    logic [TW-1:0] cmd_timeout;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready, out_last;
    logic [DW-1:0] out_data;
    logic          cp_active, cp_nbusy, cp_done;
    logic [AW-1:0] dmem_addr_w, dmem_addr_r;
    logic [DW-1:0] dmem_in_w, dmem_out_r;
    logic          dmem_we_w;
    logic          job_done, job_err, busy;
    logic [2:0]    dbg_state;

    cp_job_ctrl #(.CP_D_WIDTH(DW), .DMEM_ADDR_WIDTH(AW), .TIMEOUT_WIDTH(TW)) dut (
        .clock(clock), .nreset(nreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_in_base(cmd_in_base), .cmd_in_len(cmd_in_len),
        .cmd_out_base(cmd_out_base), .cmd_out_len(cmd_out_len), .cmd_timeout(cmd_timeout),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .cp_active(cp_active), .cp_nbusy(cp_nbusy), .cp_done(cp_done),
        .dmem_addr_w(dmem_addr_w), .dmem_in_w(dmem_in_w), .dmem_we_w(dmem_we_w),
        .dmem_addr_r(dmem_addr_r), .dmem_out_r(dmem_out_r),
        .job_done(job_done), .job_err(job_err), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- DMEM model (sync read, 1-cycle latency) ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          tb_we = 1'b0;
    logic [AW-1:0] tb_waddr = '0;
    logic [DW-1:0] tb_wdata = '0;
    always @(posedge clock) begin
        if (dmem_we_w) mem[dmem_addr_w] <= dmem_in_w;
        else if (tb_we) mem[tb_waddr] <= tb_wdata;
        dmem_out_r <= mem[dmem_addr_r];
    end

    // ---------------- core model: done in the Nth cycle of cp_active ----------------
    int core_delay = 0;
    int core_cnt = 0;
    initial begin
        cp_done = 1'b0;
        cp_nbusy = 1'b1;
        forever begin
            @(posedge clock); #1;
            if (cp_active) begin
                core_cnt++;
                cp_done = (core_delay != 0) && (core_cnt == core_delay);
            end else begin
                core_cnt = 0;
                cp_done = 1'b0;
            end
            cp_nbusy = !cp_active;
        end
    end

    // ---------------- scoreboard ----------------
    int checks_total = 0;
    int checks_passed = 0;
    logic [AW+DW-1:0] exp_wr_q[$];
    logic [DW:0]      exp_out_q[$];
    bit mon_en = 1'b0;
    int wr_cnt = 0, done_cnt = 0, err_cnt = 0, act_cnt = 0;
    bit ov_seen = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic fail(input string name);
        checks_total++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (dmem_we_w) begin
                wr_cnt++;
                if (mon_en) begin
                    if (exp_wr_q.size() == 0) fail("wr_extra");
                    else check("wr", {dmem_addr_w, dmem_in_w}, exp_wr_q.pop_front());
                end
            end
            if (mon_en && out_valid && out_ready) begin
                if (exp_out_q.size() == 0) fail("out_extra");
                else check("out", {out_last, out_data}, exp_out_q.pop_front());
            end
            if (out_valid) ov_seen = 1'b1;
            if (job_done) done_cnt++;
            if (job_err) err_cnt++;
            if (cp_active) act_cnt++;
        end
    end

    // ---------------- job table ----------------
    typedef struct {
        logic [AW-1:0] in_base;
        int            in_len;
        logic [AW-1:0] out_base;
        int            out_len;
        int            delay;
        int            tmo;
        bit            stall;
        bit            busy_cmd;
        int            exp_active;
        bit            exp_err;
        logic [AW-1:0] exp_last_w;
    } job_t;

    job_t jobs[8];
    int   n_jobs;

    function automatic logic [DW-1:0] op_word(input int id, input int i);
        return {8'h5A, 32'(id), 32'(i) ^ 32'h1234_5678};
    endfunction

    function automatic logic [DW-1:0] res_word(input int id, input int i);
        return {8'hC3, 32'(id * 16), 32'(i) ^ 32'hDEAD_BEEF};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic mem_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clock); #1;
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(posedge clock); #1;
        tb_we = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, ".cmd_ready"}, cmd_ready, 0);
        check({tag, ".in_ready"}, in_ready, 0);
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".out_last"}, out_last, 0);
        check({tag, ".out_data"}, out_data, 0);
        check({tag, ".cp_active"}, cp_active, 0);
        check({tag, ".dmem_we_w"}, dmem_we_w, 0);
        check({tag, ".dmem_addr_w"}, dmem_addr_w, 0);
        check({tag, ".dmem_in_w"}, dmem_in_w, 0);
        check({tag, ".dmem_addr_r"}, dmem_addr_r, 0);
        check({tag, ".job_done"}, job_done, 0);
        check({tag, ".job_err"}, job_err, 0);
    endtask

    task automatic run_job(input job_t j, input int id);
        logic [AW-1:0] a;
        logic [DW-1:0] held;
        int  cyc, stall_seen;
        bit  hs, ended, prev_active, prev_hs_last;
        held = '0;
        for (int i = 0; i < j.out_len; i++) begin
            a = j.out_base + AW'(i);
            mem_load(a, res_word(id, i));
            if (!j.exp_err) exp_out_q.push_back({(i == j.out_len - 1), res_word(id, i)});
        end
        for (int i = 0; i < j.in_len; i++) begin
            a = j.in_base + AW'(i);
            exp_wr_q.push_back({a, op_word(id, i)});
        end
        done_cnt = 0; err_cnt = 0; act_cnt = 0; ov_seen = 1'b0;
        core_delay = j.delay;
        out_ready = !j.stall;

        @(posedge clock); #1;
        cmd_valid = 1'b1;
        cmd_in_base = j.in_base;   cmd_in_len = AW'(j.in_len);
        cmd_out_base = j.out_base; cmd_out_len = AW'(j.out_len);
        cmd_timeout = TW'(j.tmo);
        @(negedge clock);
        check("cmd_ready", cmd_ready, 1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;

        if (j.in_len == 0) begin
            @(negedge clock);
            check("run_lat", cp_active, 1);
        end else begin
            for (int i = 0; i < j.in_len; i++) begin
                in_valid = 1'b1;
                in_data = op_word(id, i);
                cyc = 0; hs = 1'b0;
                while (!hs && cyc < 20) begin
                    @(negedge clock); hs = in_ready;
                    @(posedge clock); #1; cyc++;
                end
                if (!hs) begin
                    fail("in_hs_timeout");
                    break;
                end
            end
            in_valid = 1'b0;
            @(negedge clock);
            check("run_lat", cp_active, 1);
            check("last_waddr", dmem_addr_w, j.exp_last_w);
        end

        prev_active = 1'b1; prev_hs_last = 1'b0; stall_seen = 0; ended = 1'b0;
        for (cyc = 0; cyc < 400 && !ended; cyc++) begin
            @(negedge clock);
            if (job_done) begin
                ended = 1'b1;
                check("done_timing", (j.out_len == 0 || j.exp_err) ? prev_active : prev_hs_last, 1);
            end else begin
                if (j.busy_cmd) check("cmd_ready_busy", cmd_ready, 0);
                if (j.stall && out_valid && stall_seen < 5) begin
                    if (stall_seen == 0) held = out_data;
                    else check("stall_stable", out_data, held);
                    stall_seen++;
                end
                prev_active = cp_active;
                prev_hs_last = out_valid && out_ready && out_last;
                @(posedge clock); #1;
                if (stall_seen == 5) out_ready = 1'b1;
                if (j.busy_cmd) begin
                    cmd_valid = prev_active;
                    cmd_in_base = 10'h155; cmd_in_len = 10'd7;
                    cmd_out_base = 10'h2AA; cmd_out_len = 10'd3;
                    cmd_timeout = 16'd2;
                end
            end
        end
        if (!ended) fail("job_done_timeout");
        cmd_valid = 1'b0;
        out_ready = 1'b1;

        @(negedge clock);
        check("done_pulse", job_done, 0);
        check("cmd_ready_idle", cmd_ready, 1);
        check("busy_idle", busy, 0);
        check("done_cnt", done_cnt, 1);
        check("err_cnt", err_cnt, j.exp_err);
        check("active_cycles", act_cnt, j.exp_active);
        check("wr_left", exp_wr_q.size(), 0);
        check("out_left", exp_out_q.size(), 0);
        check("out_valid_seen", ov_seen, (j.out_len != 0 && !j.exp_err));
        exp_wr_q.delete();
        exp_out_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int snap;
        nreset = 1'b0;
        cmd_valid = 1'b0; cmd_in_base = '0; cmd_in_len = '0;
        cmd_out_base = '0; cmd_out_len = '0; cmd_timeout = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_outs("por");
        @(posedge clock); #1;
        nreset = 1'b1;
        @(negedge clock);
        check("cmd_ready_after_por", cmd_ready, 1);

        //          in_base  in_len out_base out_len delay tmo stall busy  act err last_w
        jobs[0] = '{10'h010, 3, 10'h020, 2, 20, 0, 1'b0, 1'b0, 20, 1'b0, 10'h012};
        jobs[1] = '{10'h3FE, 4, 10'h200, 1,  3, 0, 1'b0, 1'b0,  3, 1'b0, 10'h001};
        jobs[2] = '{10'h040, 1, 10'h3FF, 3,  5, 0, 1'b1, 1'b0,  5, 1'b0, 10'h040};
        jobs[3] = '{10'h000, 0, 10'h000, 0,  7, 0, 1'b0, 1'b1,  7, 1'b0, 10'h000};
        jobs[4] = '{10'h080, 2, 10'h090, 1, 12, 0, 1'b0, 1'b1, 12, 1'b0, 10'h081};
`ifdef CP_JOB_TIMEOUT_EN
        jobs[5] = '{10'h0A0, 1, 10'h0B0, 2,  0, 10, 1'b0, 1'b0, 10, 1'b1, 10'h0A0};
        jobs[6] = '{10'h0C0, 1, 10'h0D0, 2, 10, 10, 1'b0, 1'b0, 10, 1'b0, 10'h0C0};
        n_jobs = 7;
`else
        jobs[5] = '{10'h0A0, 1, 10'h0B0, 1,  8, 3, 1'b0, 1'b0,  8, 1'b0, 10'h0A0};
        n_jobs = 6;
`endif

        mon_en = 1'b1;
        for (int k = 0; k < n_jobs; k++) run_job(jobs[k], k);
        mon_en = 1'b0;

        // reset in the middle of LOAD with in_len=5
        core_delay = 0;
        @(posedge clock); #1;
        cmd_valid = 1'b1; cmd_in_base = 10'h100; cmd_in_len = 10'd5;
        cmd_out_base = 10'h000; cmd_out_len = 10'd1; cmd_timeout = '0;
        @(posedge clock); #1;
        cmd_valid = 1'b0; in_valid = 1'b1; in_data = op_word(9, 0);
        @(posedge clock); #1;
        in_data = op_word(9, 1);
        @(posedge clock); #1;
        check("mid_load_state", dbg_state, 3'd1);
        nreset = 1'b0;
        @(negedge clock);
        for (int r = 0; r < 3; r++) begin
            @(posedge clock);
            @(negedge clock);
            check_reset_outs("rst_mid");
            check("rst_state", dbg_state, 3'd0);
        end
        snap = wr_cnt;
        @(posedge clock); #1;
        nreset = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        check("cmd_ready_after_rst", cmd_ready, 1);
        repeat (5) @(negedge clock);
        check("no_wr_after_rst", wr_cnt, snap);
        check("busy_after_rst", busy, 0);
        check("in_ready_after_rst", in_ready, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
